// File: rtl/strobe_monitor.sv
// Receive-side checker for a periodic strobe: detects rising edges, measures the
// edge-to-edge interval and flags early or missing strobes against EXP_PERIOD +/- TOL.
module strobe_monitor #(
  parameter int unsigned EXP_PERIOD = 4,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_N     = 2
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       strobe_in,
  output logic       edge_pulse,
  output logic [7:0] strobe_count,
  output logic [7:0] period_out,
  output logic       locked,
  output logic       err_early,
  output logic       err_missing,
  output logic [7:0] err_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    FAULT      = 2'd2
  } state_t;

  localparam logic [7:0] LO_CYC   = 8'(EXP_PERIOD - TOL);
  localparam logic [7:0] HI_CYC   = 8'(EXP_PERIOD + TOL);
  localparam logic [3:0] LOCK_CNT = 4'(LOCK_N);

  state_t     state;
  logic       strb_q;
  logic [7:0] gap_cnt;
  logic [3:0] good_run;
  logic [3:0] good_next;
  logic [7:0] err_next;
  logic       edge_det;

  assign edge_det  = strobe_in & ~strb_q;
  assign state_dbg = state;

  always_comb begin
    good_next = (good_run >= LOCK_CNT) ? LOCK_CNT : good_run + 4'd1;
    err_next  = (err_count == 8'hff) ? err_count : err_count + 8'd1;
  end

  // Valid/ready is not used here: edge_pulse, err_early and err_missing are
  // single-cycle strobes with no back-pressure; the status words are level outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_FIRST;
      strb_q       <= 1'b0;
      gap_cnt      <= 8'd0;
      good_run     <= 4'd0;
      edge_pulse   <= 1'b0;
      strobe_count <= 8'd0;
      period_out   <= 8'd0;
      locked       <= 1'b0;
      err_early    <= 1'b0;
      err_missing  <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      strb_q      <= strobe_in;
      edge_pulse  <= edge_det;
      err_early   <= 1'b0;
      err_missing <= 1'b0;

      // gap_cnt holds the number of cycles since the last edge, so at an edge it is the interval.
      if (edge_det) begin
        gap_cnt      <= 8'd1;
        strobe_count <= strobe_count + 8'd1;
      end else if (gap_cnt != 8'hff) begin
        gap_cnt <= gap_cnt + 8'd1;
      end

      case (state)
        WAIT_FIRST: begin
          if (edge_det) state <= MEASURE;
        end
        MEASURE: begin
          if (edge_det) begin
            period_out <= gap_cnt;
            if (gap_cnt < LO_CYC) begin
              err_early <= 1'b1;
              err_count <= err_next;
              good_run  <= 4'd0;
              locked    <= 1'b0;
            end else begin
              good_run <= good_next;
              if (good_next >= LOCK_CNT) locked <= 1'b1;
            end
          end else if (gap_cnt == HI_CYC) begin
            // An edge landing exactly on HI_CYC is taken above as in tolerance.
            err_missing <= 1'b1;
            err_count   <= err_next;
            good_run    <= 4'd0;
            locked      <= 1'b0;
            state       <= FAULT;
          end
        end
        FAULT: begin
          if (edge_det) state <= MEASURE;
        end
        default: state <= WAIT_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_strobe_monitor.sv
// Bench for strobe_monitor: directed strobe patterns, an expected-event queue popped
// by a monitor on every DUT pulse, plus hand-computed status checks at phase ends.
module tb_strobe_monitor;

  localparam int EXP    = 4;
  localparam int TOL    = 0;
  localparam int LOCK_N = 2;

  logic       clk_in;
  logic       rst_n;
  logic       strobe_in;
  logic       edge_pulse;
  logic [7:0] strobe_count;
  logic [7:0] period_out;
  logic       locked;
  logic       err_early;
  logic       err_missing;
  logic [7:0] err_count;
  logic [1:0] state_dbg;

  strobe_monitor #(.EXP_PERIOD(EXP), .TOL(TOL), .LOCK_N(LOCK_N)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .strobe_in   (strobe_in),
    .edge_pulse  (edge_pulse),
    .strobe_count(strobe_count),
    .period_out  (period_out),
    .locked      (locked),
    .err_early   (err_early),
    .err_missing (err_missing),
    .err_count   (err_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [43:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int pulses_seen = 0;

  function automatic logic [43:0] pack(int n, logic e, logic a, logic m,
                                       int cnt, int per, logic lk, int er);
    return {16'(n), e, a, m, 8'(cnt), 8'(per), lk, 8'(er)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_n && (edge_pulse || err_early || err_missing)) begin
      logic [43:0] act;
      logic [43:0] exp;
      act = pack(cyc, edge_pulse, err_early, err_missing,
                 int'(strobe_count), int'(period_out), locked, int'(err_count));
      if (edge_pulse) pulses_seen++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d: actual=%h required=none", cyc, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_bad++;
          $display("FAIL event cyc=%0d: actual=%h required=%h", cyc, act, exp);
        end
      end
    end
  end

  // ---------------- reference behaviour ----------------
  int   m_state;   // 0 waiting for first edge, 1 measuring, 2 fault
  logic m_prev;
  int   m_last;
  int   m_good;
  logic m_locked;
  int   m_period;
  int   m_count;
  int   m_errs;

  task automatic model_reset();
    m_state = 0; m_prev = 1'b0; m_last = 0; m_good = 0;
    m_locked = 1'b0; m_period = 0; m_count = 0; m_errs = 0;
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic s);
    int   n;
    int   p;
    logic rise;
    logic early;
    logic miss;
    n = cyc + 1;
    rise = s && !m_prev;
    m_prev = s;
    early = 1'b0;
    miss = 1'b0;
    if (rise) begin
      m_count = (m_count + 1) % 256;
      if (m_state == 1) begin
        p = n - m_last;
        m_period = p;
        if (p < EXP - TOL) begin
          early = 1'b1; m_good = 0; m_locked = 1'b0;
        end else begin
          if (m_good < LOCK_N) m_good++;
          if (m_good >= LOCK_N) m_locked = 1'b1;
        end
      end else begin
        m_state = 1;
      end
      m_last = n;
    end else if (m_state == 1 && n - m_last == EXP + TOL) begin
      miss = 1'b1; m_good = 0; m_locked = 1'b0; m_state = 2;
    end
    if ((early || miss) && m_errs < 255) m_errs++;
    if (rise || early || miss)
      exp_q.push_back(pack(n, rise, early, miss, m_count, m_period, m_locked, m_errs));
    strobe_in = s;
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_in);
    #1;
  endtask

  task automatic async_reset();
    settle();
    check("queue_drained_before_reset", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_edge_pulse", int'(edge_pulse), 0);
    check("async_rst_count", int'(strobe_count), 0);
    check("async_rst_period", int'(period_out), 0);
    check("async_rst_locked", int'(locked), 0);
    check("async_rst_err_count", int'(err_count), 0);
    check("async_rst_state", int'(state_dbg), 0);
    model_reset();
    strobe_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst_n = 1'b0;
    strobe_in = 1'b0;
    model_reset();
    #12;
    check("rst_edge_pulse", int'(edge_pulse), 0);
    check("rst_count", int'(strobe_count), 0);
    check("rst_period", int'(period_out), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_state", int'(state_dbg), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    #1;

    // Nominal: one-cycle strobe every 4 clocks, 5 strobes
    tick(1'b0); tick(1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      if (i == 0) check("nom_first_edge_period", int'(period_out), 0);
      if (i == 1) check("nom_period_edge2", int'(period_out), 4);
      if (i == 1) check("nom_unlocked_edge2", int'(locked), 0);
      if (i == 2) check("nom_locked_edge3", int'(locked), 1);
      if (i < 4) repeat (3) tick(1'b0);
    end
    check("nom_count", int'(strobe_count), 5);
    check("nom_period", int'(period_out), 4);
    check("nom_locked", int'(locked), 1);
    check("nom_err_count", int'(err_count), 0);

    // Early: next edge only 2 clocks after the last one
    tick(1'b0); tick(1'b1);
    check("early_pulse", int'(err_early), 1);
    check("early_period", int'(period_out), 2);
    check("early_locked", int'(locked), 0);
    check("early_err_count", int'(err_count), 1);
    repeat (3) tick(1'b0); tick(1'b1);
    check("early_relock_1", int'(locked), 0);
    repeat (3) tick(1'b0); tick(1'b1);
    check("early_relock_2", int'(locked), 1);

    // Missing: strobe stops; pulse 4 clocks after the last edge
    repeat (3) tick(1'b0);
    check("missing_not_yet", int'(err_missing), 0);
    tick(1'b0);
    check("missing_pulse", int'(err_missing), 1);
    check("missing_err_count", int'(err_count), 2);
    check("missing_locked", int'(locked), 0);
    check("missing_state_fault", int'(state_dbg), 2);
    repeat (2) tick(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      if (i < 2) repeat (3) tick(1'b0);
    end
    check("resync_locked", int'(locked), 1);
    check("resync_err_count", int'(err_count), 2);

    // Async reset while locked, then a strobe held high for 10 cycles
    async_reset();
    base = pulses_seen;
    tick(1'b0); tick(1'b0);
    repeat (10) tick(1'b1);
    repeat (2) tick(1'b0);
    settle();
    check("held_single_pulse", pulses_seen - base, 1);
    check("held_count", int'(strobe_count), 1);
    check("held_no_period_update", int'(period_out), 0);

    // Wrap / saturate: 301 edges 2 clocks apart -> 300 early events
    async_reset();
    for (int i = 0; i < 301; i++) begin
      tick(1'b1);
      if (i == 255) check("wrap_count_256", int'(strobe_count), 0);
      tick(1'b0);
    end
    settle();
    check("sat_err_count", int'(err_count), 255);
    check("wrap_count_301", int'(strobe_count), 45);
    check("sat_period", int'(period_out), 2);

    settle();
    check("queue_drained_at_end", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
